rob_multiway: RTL

//  Parametrised multi-way reorder buffer, the successor to the single-way rob skeleton.
//  - Allocates up to DISPATCH_WAY entries per cycle at the tail, in program order.
//  - Accepts out-of-order completions from COMPLETE_PORTS pipelines.
//  - Retires up to COMMIT_WAY completed entries per cycle from the head; each retirement frees the old physical register.
//  - An exception reaching the head flushes the whole buffer and raises a one-cycle restart.
//  - Sits between rename/dispatch and the free list / front-end redirect.

---
 rtl/rob_multiway.sv | 297 +++++++++++++++++++++++++++++
 1 files changed

// File: rtl/rob_multiway.sv
// -----------------------------------------------------------------------------
// rob_multiway
//   Multi-way reorder buffer. Up to DISPATCH_WAY entries are allocated at the
//   tail each cycle, in program order. COMPLETE_PORTS pipelines mark entries
//   complete out of order. Up to COMMIT_WAY entries retire from the head each
//   cycle; each retirement returns the entry's old physical register. A
//   completed, excepting entry at the head does not retire. It flushes the
//   whole buffer and produces a one-cycle restart pulse carrying its PC and
//   cause.
//
// Optional feature (compile-time macro ROB_UNEXCEPTABLE_HEAD_EN):
//   Adds a per-entry "unexceptable" bit, the input complete_unexceptable and
//   the output ux_head_index. ux_head_index runs ahead of the head across
//   contiguous unexceptable entries, so stores/AMOs can launch early.
//
// Ports
//   CLK, nRST                  clock (rising edge), asynchronous active-low reset
//   dispatch_valid_by_way      allocation requests, contiguous from way 0
//   dispatch_pc/ar/old_pr_by_way  per-way payload written into the entry
//   dispatch_ready             room for a full dispatch group and no flush
//   dispatch_base_index        entry index given to way 0 (way k gets base+k)
//   complete_valid/index       completion strobes and target entries
//   complete_exception/cause   exception flag and cause per completion port
//   commit_valid_by_way        retire strobes, contiguous from way 0
//   commit_ar/old_pr_by_way    retired arch reg / physical reg to free
//   restart_valid/pc/cause     one-cycle flush/redirect pulse and its payload
//   head_index, rob_empty      current head entry and empty flag
//   complete_unexceptable      (macro only) marks an entry unexceptable
//   ux_head_index              (macro only) first entry that is not yet unexceptable
// -----------------------------------------------------------------------------
module rob_multiway #(
  parameter int ROB_ENTRIES    = 64,
  parameter int DISPATCH_WAY   = 4,
  parameter int COMMIT_WAY     = 4,
  parameter int COMPLETE_PORTS = 4,
  parameter int AR_W           = 5,
  parameter int PR_W           = 7,
  parameter int PC_W           = 32,
  parameter int CAUSE_W        = 4,
  localparam int IX            = $clog2(ROB_ENTRIES)
) (
  input  logic                              CLK,
  input  logic                              nRST,
  input  logic [DISPATCH_WAY-1:0]           dispatch_valid_by_way,
  input  logic [DISPATCH_WAY*PC_W-1:0]      dispatch_pc_by_way,
  input  logic [DISPATCH_WAY*AR_W-1:0]      dispatch_ar_by_way,
  input  logic [DISPATCH_WAY*PR_W-1:0]      dispatch_old_pr_by_way,
  output logic                              dispatch_ready,
  output logic [IX-1:0]                     dispatch_base_index,
  input  logic [COMPLETE_PORTS-1:0]         complete_valid,
  input  logic [COMPLETE_PORTS*IX-1:0]      complete_index,
  input  logic [COMPLETE_PORTS-1:0]         complete_exception,
  input  logic [COMPLETE_PORTS*CAUSE_W-1:0] complete_cause,
  output logic [COMMIT_WAY-1:0]             commit_valid_by_way,
  output logic [COMMIT_WAY*AR_W-1:0]        commit_ar_by_way,
  output logic [COMMIT_WAY*PR_W-1:0]        commit_old_pr_by_way,
  output logic                              restart_valid,
  output logic [PC_W-1:0]                   restart_pc,
  output logic [CAUSE_W-1:0]                restart_cause,
  output logic [IX-1:0]                     head_index,
`ifdef ROB_UNEXCEPTABLE_HEAD_EN
  input  logic [COMPLETE_PORTS-1:0]         complete_unexceptable,
  output logic [IX-1:0]                     ux_head_index,
`endif
  output logic                              rob_empty
);

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  localparam int PW = IX + 1;
  localparam logic [PW-1:0] ENTRIES_P = PW'(ROB_ENTRIES);
  localparam logic [PW-1:0] DISP_P    = PW'(DISPATCH_WAY);

  function automatic logic [PW-1:0] count_ways(input logic [DISPATCH_WAY-1:0] v);
    logic [PW-1:0] n;
    n = '0;
    for (int k = 0; k < DISPATCH_WAY; k++) n = n + PW'(v[k]);
    return n;
  endfunction

  // Control state
  logic [PW-1:0]          head, tail;
  logic [ROB_ENTRIES-1:0] valid, complete, exception;

  // Entry payload (not reset; qualified by valid)
  logic [PC_W-1:0]    pc_mem     [ROB_ENTRIES];
  logic [AR_W-1:0]    ar_mem     [ROB_ENTRIES];
  logic [PR_W-1:0]    old_pr_mem [ROB_ENTRIES];
  logic [CAUSE_W-1:0] cause_mem  [ROB_ENTRIES];

  logic [IX-1:0] head_i, tail_i;
  logic [PW-1:0] occupancy, free_cnt, disp_cnt, commit_cnt;
  logic          exc_head;

  assign head_i    = head[IX-1:0];
  assign tail_i    = tail[IX-1:0];
  assign occupancy = tail - head;
  assign free_cnt  = ENTRIES_P - occupancy;
  assign disp_cnt  = count_ways(dispatch_valid_by_way);

  // A completed excepting head triggers the flush on this edge; no dispatch is
  // accepted in this cycle or in the following restart cycle.
  assign exc_head = valid[head_i] & complete[head_i] & exception[head_i];

  assign dispatch_ready      = (free_cnt >= DISP_P) & ~restart_valid & ~exc_head;
  assign dispatch_base_index = tail_i;
  assign head_index          = head_i;
  assign rob_empty           = (head == tail);

  // Entry indices touched by each dispatch way and each commit way (mod size)
  logic [IX-1:0] disp_idx   [DISPATCH_WAY];
  logic [IX-1:0] commit_idx [COMMIT_WAY];

  for (genvar k = 0; k < DISPATCH_WAY; k++) begin : g_disp_idx
    assign disp_idx[k] = tail_i + IX'(k);
  end

  for (genvar k = 0; k < COMMIT_WAY; k++) begin : g_commit_idx
    assign commit_idx[k] = head_i + IX'(k);
  end

  // Commit: way k fires only while every entry from the head up to it is
  // valid, complete and free of exceptions.
  logic chain;

  always_comb begin
    commit_valid_by_way  = '0;
    commit_ar_by_way     = '0;
    commit_old_pr_by_way = '0;
    commit_cnt           = '0;
    chain                = 1'b1;
    for (int k = 0; k < COMMIT_WAY; k++) begin
      chain = chain & valid[commit_idx[k]] & complete[commit_idx[k]]
                    & ~exception[commit_idx[k]];
      commit_valid_by_way[k]              = chain;
      commit_ar_by_way[k*AR_W +: AR_W]    = ar_mem[commit_idx[k]];
      commit_old_pr_by_way[k*PR_W +: PR_W] = old_pr_mem[commit_idx[k]];
      commit_cnt = commit_cnt + PW'(chain);
    end
  end

  // Completion decode per entry. Ports hitting the same entry OR together; the
  // descending scan leaves the lowest-numbered excepting port's cause.
  logic [ROB_ENTRIES-1:0] cpl_set, cpl_exc;
  logic [CAUSE_W-1:0]     cpl_cause [ROB_ENTRIES];
`ifdef ROB_UNEXCEPTABLE_HEAD_EN
  logic [ROB_ENTRIES-1:0] ux_set;
`endif

  for (genvar e = 0; e < ROB_ENTRIES; e++) begin : g_cpl
    logic               hit, exc;
    logic [CAUSE_W-1:0] cause;

    always_comb begin
      hit   = 1'b0;
      exc   = 1'b0;
      cause = '0;
      for (int p = COMPLETE_PORTS - 1; p >= 0; p--) begin
        if (complete_valid[p] && (complete_index[p*IX +: IX] == IX'(e))) begin
          hit = 1'b1;
          if (complete_exception[p]) begin
            exc   = 1'b1;
            cause = complete_cause[p*CAUSE_W +: CAUSE_W];
          end
        end
      end
    end

    // Completions to free entries or during the restart cycle are dropped.
    assign cpl_set[e]   = hit & valid[e] & ~restart_valid;
    assign cpl_exc[e]   = exc;
    assign cpl_cause[e] = cause;

`ifdef ROB_UNEXCEPTABLE_HEAD_EN
    // An entry becomes unexceptable by an explicit mark (which need not come
    // with a completion) or by completing without an exception.
    logic ux_hit;

    always_comb begin
      ux_hit = 1'b0;
      for (int p = 0; p < COMPLETE_PORTS; p++) begin
        if ((complete_index[p*IX +: IX] == IX'(e)) &&
            (complete_unexceptable[p] || (complete_valid[p] && !complete_exception[p])))
          ux_hit = 1'b1;
      end
    end

    assign ux_set[e] = ux_hit & valid[e] & ~restart_valid;
`endif
  end

  // Per-entry strobes for retirement and allocation
  logic [ROB_ENTRIES-1:0] commit_clr, disp_set;

  always_comb begin
    commit_clr = '0;
    disp_set   = '0;
    for (int k = 0; k < COMMIT_WAY; k++)
      if (commit_valid_by_way[k]) commit_clr[commit_idx[k]] = 1'b1;
    for (int k = 0; k < DISPATCH_WAY; k++)
      if (dispatch_ready && dispatch_valid_by_way[k]) disp_set[disp_idx[k]] = 1'b1;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      head          <= '0;
      tail          <= '0;
      valid         <= '0;
      complete      <= '0;
      exception     <= '0;
      restart_valid <= 1'b0;
    end else begin
      restart_valid <= exc_head;
      if (exc_head) begin
        // Flush: drop every entry and pull the tail back to the head.
        valid     <= '0;
        complete  <= '0;
        exception <= '0;
        tail      <= head;
      end else begin
        head <= head + commit_cnt;
        if (dispatch_ready) tail <= tail + disp_cnt;
        for (int e = 0; e < ROB_ENTRIES; e++) begin
          if (cpl_set[e]) begin
            complete[e] <= 1'b1;
            if (cpl_exc[e]) exception[e] <= 1'b1;
          end
          if (commit_clr[e]) valid[e] <= 1'b0;
          if (disp_set[e]) begin
            valid[e]     <= 1'b1;
            complete[e]  <= 1'b0;
            exception[e] <= 1'b0;
          end
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    for (int k = 0; k < DISPATCH_WAY; k++) begin
      if (dispatch_ready && dispatch_valid_by_way[k]) begin
        pc_mem[disp_idx[k]]     <= dispatch_pc_by_way[k*PC_W +: PC_W];
        ar_mem[disp_idx[k]]     <= dispatch_ar_by_way[k*AR_W +: AR_W];
        old_pr_mem[disp_idx[k]] <= dispatch_old_pr_by_way[k*PR_W +: PR_W];
      end
    end
    for (int e = 0; e < ROB_ENTRIES; e++)
      if (cpl_set[e] && cpl_exc[e]) cause_mem[e] <= cpl_cause[e];
    if (exc_head) begin
      restart_pc    <= pc_mem[head_i];
      restart_cause <= cause_mem[head_i];
    end
  end

`ifdef ROB_UNEXCEPTABLE_HEAD_EN
  logic [ROB_ENTRIES-1:0] ux;
  logic [PW-1:0]          ux_ptr, ux_dist, ux_start, ux_cnt;
  logic [IX-1:0]          ux_idx [COMMIT_WAY];
  logic                   ux_chain;

  // Once commits overtake the stored pointer it lies outside head..tail; the
  // head is then the correct starting point.
  assign ux_dist       = ux_ptr - head;
  assign ux_start      = (ux_dist > occupancy) ? head : ux_ptr;
  assign ux_head_index = ux_start[IX-1:0];

  for (genvar k = 0; k < COMMIT_WAY; k++) begin : g_ux_idx
    assign ux_idx[k] = ux_start[IX-1:0] + IX'(k);
  end

  // Entries past the tail are never valid, so the scan cannot pass the tail.
  always_comb begin
    ux_cnt   = '0;
    ux_chain = 1'b1;
    for (int k = 0; k < COMMIT_WAY; k++) begin
      ux_chain = ux_chain & valid[ux_idx[k]] & ux[ux_idx[k]];
      ux_cnt   = ux_cnt + PW'(ux_chain);
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      ux     <= '0;
      ux_ptr <= '0;
    end else if (exc_head) begin
      ux     <= '0;
      ux_ptr <= head;
    end else begin
      ux_ptr <= ux_start + ux_cnt;
      for (int e = 0; e < ROB_ENTRIES; e++) begin
        if (ux_set[e])   ux[e] <= 1'b1;
        if (disp_set[e]) ux[e] <= 1'b0;
      end
    end
  end
`endif

endmodule
